// File: rtl/fp_ld_align.sv
// fp_ld_align: aligns FP load operands from 128-bit cache beats.
// Byte reversal via FPLD_BSWAP_EN.
module fp_ld_align #(
  parameter int TAG_W = 9,
  parameter int SKID  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [127:0]     in_data,
  input  logic [3:0]       in_off,
  input  logic             in_dbl,
  input  logic [1:0]       in_fmt,
  input  logic [TAG_W-1:0] in_tag,
`ifdef FPLD_BSWAP_EN
  input  logic             in_be,
`endif
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [64:0]      out_A,
  output logic             out_en,
  output logic             out_to_sngl,
  output logic             out_to_dbl,
  output logic             out_to_ext,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic {
    IDLE,
    HI
  } st_t;

  typedef struct packed {
    logic [63:0]      a;
    logic             sngl;
    logic             dbl;
    logic             ext;
    logic [TAG_W-1:0] tag;
  } op_t;

  st_t              st;
  logic [63:0]      l_q;
  logic [3:0]       n1_q;
  logic             dbl_q;
  logic [1:0]       fmt_q;
  logic [TAG_W-1:0] tag_q;
  op_t              out_q;
  op_t              skid_q;
  logic             skid_vld;

  logic [4:0]       nb;
  logic             split;
  logic [3:0]       n1;
  logic [63:0]      sh;
  logic [63:0]      hi_sh;
  logic [63:0]      raw;
  logic [63:0]      asm_v;
  logic [63:0]      fin;
  logic             sel_dbl;
  logic [1:0]       sel_fmt;
  logic             in_hi;
  logic             accept;
  logic             produce;
  logic             out_free;
  op_t              new_op;

  assign in_hi = (st == HI);
  assign nb    = in_dbl ? 5'd8 : 5'd4;
  assign split = ({1'b0, in_off} + nb) > 5'd16;
  assign n1    = 4'(5'd16 - {1'b0, in_off});

  // Shifted-down beat doubles as the split low part L.
  assign sh    = 64'(in_data >> {in_off, 3'b000});
  assign hi_sh = 64'(in_data << {n1_q, 3'b000});

  assign raw     = in_hi ? (l_q | hi_sh) : sh;
  assign sel_dbl = in_hi ? dbl_q : in_dbl;
  assign sel_fmt = in_hi ? fmt_q : in_fmt;
  assign asm_v   = sel_dbl ? raw : {32'b0, raw[31:0]};

`ifdef FPLD_BSWAP_EN
  logic        be_q;
  logic        be_sel;
  logic [63:0] rev64;
  logic [31:0] rev32;
  assign be_sel = in_hi ? be_q : in_be;
  assign rev64  = {<<8{asm_v}};
  assign rev32  = {<<8{asm_v[31:0]}};
  assign fin    = !be_sel ? asm_v :
                  sel_dbl ? rev64 :
                  {32'b0, rev32};
`else
  assign fin = asm_v;
`endif

  always_comb begin
    new_op      = '0;
    new_op.a    = fin;
    new_op.tag  = in_hi ? tag_q : in_tag;
    unique case (1'b1)
      (sel_fmt == 2'd0): new_op.sngl = 1'b1;
      (sel_fmt == 2'd2): new_op.ext  = 1'b1;
      default:           new_op.dbl  = 1'b1;
    endcase
  end

  assign out_free = ~out_vld | out_rdy;
  assign in_rdy   = (SKID != 0) ? ~skid_vld : out_free;
  assign accept   = in_vld & in_rdy;
  assign produce  = accept & (in_hi | ~split);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= IDLE;
      l_q      <= '0;
      n1_q     <= '0;
      dbl_q    <= 1'b0;
      fmt_q    <= '0;
      tag_q    <= '0;
`ifdef FPLD_BSWAP_EN
      be_q     <= 1'b0;
`endif
      out_q    <= '0;
      out_vld  <= 1'b0;
      skid_q   <= '0;
      skid_vld <= 1'b0;
    end else if (flush) begin
      st       <= IDLE;
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
    end else begin
      if (accept) begin
        if (in_hi) begin
          st <= IDLE;
        end else if (split) begin
          st    <= HI;
          l_q   <= sh;
          n1_q  <= n1;
          dbl_q <= in_dbl;
          fmt_q <= in_fmt;
          tag_q <= in_tag;
`ifdef FPLD_BSWAP_EN
          be_q  <= in_be;
`endif
        end
      end
      if (skid_vld && out_rdy) begin
        out_q    <= skid_q;
        out_vld  <= 1'b1;
        skid_vld <= produce;
        if (produce) skid_q <= new_op;
      end else if (out_free) begin
        out_vld <= produce;
        if (produce) out_q <= new_op;
      end else if (produce && SKID != 0) begin
        skid_q   <= new_op;
        skid_vld <= 1'b1;
      end
    end
  end

  assign out_A       = {1'b0, out_q.a};
  assign out_en      = out_vld;
  assign out_to_sngl = out_q.sngl;
  assign out_to_dbl  = out_q.dbl;
  assign out_to_ext  = out_q.ext;
  assign out_tag     = out_q.tag;

endmodule

// File: tb/tb_fp_ld_align.sv
// tb_fp_ld_align: directed checks of alignment, split merge,
// backpressure, flush and async reset.
module tb_fp_ld_align;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         in_vld;
  logic         in_rdy;
  logic [127:0] in_data;
  logic [3:0]   in_off;
  logic         in_dbl;
  logic [1:0]   in_fmt;
  logic [8:0]   in_tag;
`ifdef FPLD_BSWAP_EN
  logic         in_be;
`endif
  logic         out_vld;
  logic         out_rdy;
  logic [64:0]  out_A;
  logic         out_en;
  logic         out_to_sngl;
  logic         out_to_dbl;
  logic         out_to_ext;
  logic [8:0]   out_tag;

  int errs;
  int checks;

  fp_ld_align #(.TAG_W(9), .SKID(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_vld      (in_vld),
    .in_rdy      (in_rdy),
    .in_data     (in_data),
    .in_off      (in_off),
    .in_dbl      (in_dbl),
    .in_fmt      (in_fmt),
    .in_tag      (in_tag),
`ifdef FPLD_BSWAP_EN
    .in_be       (in_be),
`endif
    .out_vld     (out_vld),
    .out_rdy     (out_rdy),
    .out_A       (out_A),
    .out_en      (out_en),
    .out_to_sngl (out_to_sngl),
    .out_to_dbl  (out_to_dbl),
    .out_to_ext  (out_to_ext),
    .out_tag     (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [64:0] got,
                     input logic [64:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [127:0] d,
                       input logic [3:0] off,
                       input logic dbl,
                       input logic [1:0] fmt,
                       input logic [8:0] tag);
    in_vld  = 1'b1;
    in_data = d;
    in_off  = off;
    in_dbl  = dbl;
    in_fmt  = fmt;
    in_tag  = tag;
  endtask

  initial begin
    errs    = 0;
    checks  = 0;
    rst     = 1'b1;
    flush   = 1'b0;
    in_vld  = 1'b0;
    in_data = '0;
    in_off  = '0;
    in_dbl  = 1'b0;
    in_fmt  = '0;
    in_tag  = '0;
    out_rdy = 1'b1;
`ifdef FPLD_BSWAP_EN
    in_be   = 1'b0;
`endif
    #12;
    chk("rst_vld", 65'(out_vld), 65'd0);
    chk("rst_A", out_A, 65'd0);
    chk("rst_rdy", 65'(in_rdy), 65'd1);
    chk("rst_tag", 65'(out_tag), 65'd0);
    chk("rst_sel", 65'({out_to_sngl, out_to_dbl, out_to_ext}), 65'd0);
    #1 rst = 1'b0;
    step();

    drive({64'h400921FB54442D18, 64'hCAFEF00D12345678},
          4'd8, 1'b1, 2'd1, 9'd5);
    step();
    chk("nd_vld", 65'(out_vld), 65'd1);
    chk("nd_en", 65'(out_en), 65'd1);
    chk("nd_A", out_A, 65'h0400921FB54442D18);
    chk("nd_sel", 65'({out_to_sngl, out_to_dbl, out_to_ext}), 65'b010);
    chk("nd_tag", 65'(out_tag), 65'd5);
    in_vld = 1'b0;
    step();
    chk("nd_drain", 65'(out_vld), 65'd0);

    drive({16'hC000, {14{8'h5A}}}, 4'd14, 1'b0, 2'd0, 9'h1A5);
    step();
    chk("ss_b1", 65'(out_vld), 65'd0);
    drive({{14{8'hA5}}, 16'h3F80}, 4'd3, 1'b1, 2'd2, 9'h000);
    step();
    chk("ss_vld", 65'(out_vld), 65'd1);
    chk("ss_A", out_A, 65'h3F80C000);
    chk("ss_tag", 65'(out_tag), 65'h1A5);
    chk("ss_sel", 65'({out_to_sngl, out_to_dbl, out_to_ext}), 65'b100);

    drive({32'hDEADBEEF, {12{8'h11}}}, 4'd12, 1'b0, 2'd2, 9'd7);
    step();
    chk("b16_A", out_A, 65'hDEADBEEF);
    chk("b16_sel", 65'({out_to_sngl, out_to_dbl, out_to_ext}), 65'b001);
    drive({{8{8'h99}}, 64'h0123456789ABCDEF}, 4'd0, 1'b1, 2'd3, 9'd8);
    step();
    chk("f3_A", out_A, 65'h0123456789ABCDEF);
    chk("f3_sel", 65'({out_to_sngl, out_to_dbl, out_to_ext}), 65'b010);

    drive({56'hAABBCCDDEEFF11, {9{8'h3C}}}, 4'd9, 1'b1, 2'd1, 9'd9);
    step();
    chk("sd_b1", 65'(out_vld), 65'd0);
    drive({{15{8'hFF}}, 8'h22}, 4'd0, 1'b0, 2'd0, 9'd0);
    step();
    chk("sd_A", out_A, 65'h022AABBCCDDEEFF11);
    chk("sd_tag", 65'(out_tag), 65'd9);
    in_vld = 1'b0;
    step();

    out_rdy = 1'b0;
    drive({{12{8'h77}}, 32'h000000A1}, 4'd0, 1'b0, 2'd0, 9'd1);
    step();
    chk("bp1_rdy", 65'(in_rdy), 65'd1);
    chk("bp1_A", out_A, 65'hA1);
    drive({{12{8'h77}}, 32'h000000A2}, 4'd0, 1'b0, 2'd0, 9'd2);
    step();
    chk("bp2_rdy", 65'(in_rdy), 65'd0);
    chk("bp2_A", out_A, 65'hA1);
    drive({{12{8'h77}}, 32'h000000A3}, 4'd0, 1'b0, 2'd0, 9'd3);
    step();
    chk("bp3_rdy", 65'(in_rdy), 65'd0);
    chk("bp3_tag", 65'(out_tag), 65'd1);
    out_rdy = 1'b1;
    step();
    chk("bp4_A", out_A, 65'hA2);
    chk("bp4_tag", 65'(out_tag), 65'd2);
    chk("bp4_rdy", 65'(in_rdy), 65'd1);
    step();
    chk("bp5_A", out_A, 65'hA3);
    chk("bp5_tag", 65'(out_tag), 65'd3);
    in_vld = 1'b0;
    step();
    chk("bp6_vld", 65'(out_vld), 65'd0);

    drive({16'hDEAD, {14{8'h00}}}, 4'd14, 1'b0, 2'd0, 9'd4);
    step();
    drive({{14{8'h00}}, 16'hBEEF}, 4'd0, 1'b0, 2'd0, 9'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_vld", 65'(out_vld), 65'd0);
    drive({24'h332211, {13{8'h00}}}, 4'd13, 1'b0, 2'd0, 9'd6);
    step();
    chk("fl_b1", 65'(out_vld), 65'd0);
    drive({{15{8'h00}}, 8'h44}, 4'd5, 1'b0, 2'd0, 9'd0);
    step();
    chk("fl_A", out_A, 65'h44332211);
    chk("fl_tag", 65'(out_tag), 65'd6);
    in_vld = 1'b0;
    step();

    out_rdy = 1'b0;
    drive({64'h0, 32'h12345678, 32'h0}, 4'd4, 1'b0, 2'd0, 9'd10);
    step();
    chk("ar_pre", 65'(out_vld), 65'd1);
    drive({16'h7777, {14{8'h00}}}, 4'd14, 1'b0, 2'd0, 9'd11);
    step();
    in_vld = 1'b0;
    chk("ar_hold", out_A, 65'h12345678);
    #2 rst = 1'b1;
    #1;
    chk("ar_vld", 65'(out_vld), 65'd0);
    chk("ar_rdy", 65'(in_rdy), 65'd1);
    chk("ar_A", out_A, 65'd0);
    #1 rst = 1'b0;
    out_rdy = 1'b1;
    drive({64'h0, 32'h55667788, 32'h0}, 4'd4, 1'b0, 2'd0, 9'd12);
    step();
    chk("ar_idle", out_A, 65'h55667788);
    chk("ar_tag", 65'(out_tag), 65'd12);

`ifdef FPLD_BSWAP_EN
    drive({96'h0, 32'h0000803F}, 4'd0, 1'b0, 2'd0, 9'd13);
    in_be = 1'b1;
    step();
    chk("be_A", out_A, 65'h3F800000);
    in_be = 1'b0;
`endif
    in_vld = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/fp_ld_align.md
Name: fp_ld_align

Overview:
- Load-data alignment stage directly upstream of the FP load converters (double and single load-to-native).
- Takes 128-bit cache read beats plus byte offset and size, and extracts the addressed single or double little-endian.
- Merges loads that cross a 16-byte boundary from two consecutive beats.
- Presents the raw operand plus en/to_sngl/to_dbl/to_ext selects through a registered valid/ready output with a one-entry skid buffer.

Parameters:
- TAG_W, 9, width of the load tag carried alongside the data.
- SKID, 1, 1 = skid entry present (full throughput); 0 = single output register, in_rdy combinational from out_rdy.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  synchronous kill of all in-flight state.
- in_vld  in  1  beat valid.
- in_rdy  out  1  stage can accept a beat.
- in_data  in  128  cache read beat.
- in_off  in  4  byte offset of the operand within the first beat.
- in_dbl  in  1  1 = 8-byte operand, 0 = 4-byte operand.
- in_fmt  in  2  destination format: 0 sngl, 1 dbl, 2 ext; 3 is illegal and is treated as 1.
- in_tag  in  TAG_W  load tag; sampled on the first beat only.
- out_vld  out  1  operand valid.
- out_rdy  in  1  converter accepts.
- out_A  out  65  operand: double in [63:0], single in [31:0], all unused bits 0.
- out_en  out  1  equals out_vld.
- out_to_sngl  out  1  decoded from fmt.
- out_to_dbl  out  1  decoded from fmt.
- out_to_ext  out  1  decoded from fmt.
- out_tag  out  TAG_W  tag of the operand.

Behaviour:
- Reset: out_vld=0, out_A=0, all to_* selects=0, out_tag=0, state=IDLE, skid empty, in_rdy=1.
- Interface clocking: one clock, clk; reset rst is asynchronous and active-high.
- Operand size: nb = in_dbl ? 8 : 4.
- Split detection: split = (in_off + nb > 16), computed with a 5-bit sum.
- Non-split extraction: operand = (in_data >> in_off*8) truncated to nb bytes.
- Split beat 1: low part L = in_data[127:in_off*8], which is n1 = 16 - in_off bytes. L, fmt, tag, dbl and n1 are latched; state goes to HI. No output is produced for this beat.
- Split beat 2 (state HI): the beat's in_off and in_dbl are ignored. Operand = L | (in_data << n1*8), truncated to nb bytes. State returns to IDLE.
- Latency: the operand appears on out_vld one cycle after the accepting edge of its last beat.
- FSM: IDLE -(accept & split)-> HI; HI -(accept)-> IDLE; any state -(flush)-> IDLE.
- Handshake: a beat is accepted when in_vld & in_rdy. Outputs hold stable while out_vld & ~out_rdy.
- Output staging:
  - The output register loads when it is empty or out_rdy=1.
  - Otherwise the produced operand goes into the skid entry.
  - in_rdy = skid empty (registered signal).
  - When out_rdy=1 and the skid is full, the skid moves into the output register in that cycle. A new operand produced in the same cycle goes into the skid.
- A split first beat never needs output space, but it is still gated by in_rdy.
- Simultaneous flush and accept: flush wins. The beat is dropped, out_vld=0 and the skid is cleared on the next cycle.
- Reset mid-split: the latched L is discarded and state=IDLE.
- Back-to-back non-split beats sustain 1 operand per clock while out_rdy=1.

Optional Feature:
- Macro: FPLD_BSWAP_EN.
- When defined: adds input in_be (1 bit, sampled per operand on its first beat). If in_be=1, the nb assembled bytes are reversed before driving out_A. Reversal applies after split merging. Adds 1 mux level and no extra latency.
- When undefined: no in_be port; data is always little-endian.

Test Plan:
- Non-split double load: in_off=8, in_dbl=1, in_fmt=1, in_data[127:64]=64'h400921FB54442D18 -> next cycle out_vld=1, out_A=65'h0400921FB54442D18, out_to_dbl=1.
- Split single load: in_off=14, in_dbl=0, beat1 in_data[127:112]=16'hC000, beat2 in_data[15:0]=16'h3F80 -> no output after beat1; one cycle after beat2, out_A[31:0]=32'h3F80C000 and tag equals beat1's tag.
- Backpressure: 3 consecutive non-split loads with out_rdy=0 -> in_rdy drops after the 2nd accept; 3rd held. Then out_rdy=1 -> operands delivered in order, one per cycle.
- Flush in HI state, with the same-cycle in_vld of beat 2 -> out_vld stays 0; the next split load merges with no stale L.
- Async reset pulse mid-cycle while out_vld=1 -> out_vld=0 immediately, in_rdy=1, state IDLE.
- With FPLD_BSWAP_EN, in_be=1, single at off=0, data 32'h0000803F -> out_A[31:0]=32'h3F800000.
